// File: rtl/branch_resolve_unit_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit_if
//   Groups the execute-side request signals and the PC / writeback / exception
//   side result signals of the branch resolve unit.
//
//   slave  : the resolve unit (consumes instruction, produces results)
//   master : the surrounding pipeline (presents instruction, consumes results)
//
//   valid_in/ready_out  instruction handshake
//   op_class, flag_sel  instruction class and condition source select
//   carry_flag          comparator flag vector
//   pc_in, offset_in    instruction PC and word offset
//   move_value          cond-move data
//   trap_ack            exception controller accepts the trap
//   pc_sel/branch_target, link_we/link_value, rd_we/rd_value,
//   trap_req/trap_pc, flush   resolved results
// ----------------------------------------------------------------------------
interface branch_resolve_unit_if;
   logic        valid_in;
   logic        ready_out;
   logic [2:0]  op_class;
   logic [1:0]  flag_sel;
   logic [3:0]  carry_flag;
   logic [31:0] pc_in;
   logic [15:0] offset_in;
   logic [31:0] move_value;
   logic        trap_ack;
   logic        pc_sel;
   logic [31:0] branch_target;
   logic        link_we;
   logic [31:0] link_value;
   logic        rd_we;
   logic [31:0] rd_value;
   logic        trap_req;
   logic [31:0] trap_pc;
   logic        flush;

   modport slave (
      input  valid_in, op_class, flag_sel, carry_flag, pc_in, offset_in,
             move_value, trap_ack,
      output ready_out, pc_sel, branch_target, link_we, link_value, rd_we,
             rd_value, trap_req, trap_pc, flush
   );

   modport master (
      output valid_in, op_class, flag_sel, carry_flag, pc_in, offset_in,
             move_value, trap_ack,
      input  ready_out, pc_sel, branch_target, link_we, link_value, rd_we,
             rd_value, trap_req, trap_pc, flush
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves branches, branch-and-link, traps and conditional moves one cycle
//   after the ALU comparator, and sequences the post-branch flush and the
//   trap handshake. All outputs are registered (latency 1 from accept).
//
//   Parameters
//     FLUSH_CYCLES  cycles of flush after a taken branch (0..15)
//     RESET_VECTOR  value of branch_target / trap_pc in and after reset
//
//   Ports
//     clk    system clock, rising edge
//     reset  synchronous reset, active low
//     bus    branch_resolve_unit_if.slave (handshake, operands, results)
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   branch_resolve_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_TRAP_WAIT
   } state_e;

   // Counter is loaded with the number of flush cycles still to follow the
   // first one, so it reaches zero on the last flush cycle.
   localparam logic [3:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

   state_e      state_q;
   logic [3:0]  flush_cnt_q;
   logic        ready_q;
   logic        pc_sel_q;
   logic [31:0] target_q;
   logic        link_we_q;
   logic [31:0] link_q;
   logic        rd_we_q;
   logic [31:0] rd_q;
   logic        trap_req_q;
   logic [31:0] trap_pc_q;
   logic        flush_q;

   logic        cond;
   logic        accept;
   logic        is_br;
   logic        is_bal;
   logic        is_trap;
   logic        is_cmov;
   logic [31:0] offset_ext;
   logic [31:0] target_d;
   logic [31:0] link_d;
   logic        unused_flag;

   // carry_flag[1] is not a selectable condition source
   assign unused_flag = bus.carry_flag[1];

   always_comb begin
      cond = 1'b1;
      unique case (bus.flag_sel)
         2'b00:   cond = bus.carry_flag[0];
         2'b01:   cond = bus.carry_flag[2];
         2'b10:   cond = bus.carry_flag[3];
         default: cond = 1'b1;
      endcase
   end

   assign is_bal  = (bus.op_class == 3'b010);
   assign is_br   = (bus.op_class == 3'b001) || is_bal;
   assign is_trap = (bus.op_class == 3'b011);
   assign is_cmov = (bus.op_class == 3'b100);

   // ready_q is only high in IDLE, so it also gates accepts in other states
   assign accept = bus.valid_in && ready_q;

   // Word offset, sign extended and scaled to bytes; all sums wrap mod 2^32
   assign offset_ext = {{14{bus.offset_in[15]}}, bus.offset_in, 2'b00};
   assign target_d   = bus.pc_in + 32'd4 + offset_ext;
   assign link_d     = bus.pc_in + 32'd8;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         flush_cnt_q <= 4'd0;
         ready_q     <= 1'b0;
         pc_sel_q    <= 1'b0;
         target_q    <= RESET_VECTOR;
         link_we_q   <= 1'b0;
         link_q      <= 32'd0;
         rd_we_q     <= 1'b0;
         rd_q        <= 32'd0;
         trap_req_q  <= 1'b0;
         trap_pc_q   <= RESET_VECTOR;
         flush_q     <= 1'b0;
      end else begin
         // pulse outputs default low so they never outlive one cycle
         pc_sel_q  <= 1'b0;
         link_we_q <= 1'b0;
         rd_we_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (accept && cond) begin
                  if (is_br) begin
                     pc_sel_q <= 1'b1;
                     target_q <= target_d;
                     if (is_bal) begin
                        link_we_q <= 1'b1;
                        link_q    <= link_d;
                     end
                     if (FLUSH_CYCLES != 0) begin
                        state_q     <= S_FLUSH;
                        flush_q     <= 1'b1;
                        ready_q     <= 1'b0;
                        flush_cnt_q <= FLUSH_LAST;
                     end
                  end
                  if (is_trap) begin
                     state_q    <= S_TRAP_WAIT;
                     trap_req_q <= 1'b1;
                     trap_pc_q  <= bus.pc_in;
                     ready_q    <= 1'b0;
                  end
                  if (is_cmov) begin
                     rd_we_q <= 1'b1;
                     rd_q    <= bus.move_value;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_cnt_q == 4'd0) begin
                  state_q <= S_IDLE;
                  flush_q <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 4'd1;
               end
            end
            S_TRAP_WAIT: begin
               // trap_req is always high here, so ack is only honoured while requested
               if (bus.trap_ack) begin
                  state_q    <= S_IDLE;
                  trap_req_q <= 1'b0;
                  ready_q    <= 1'b1;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               flush_q    <= 1'b0;
               trap_req_q <= 1'b0;
               ready_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready_out     = ready_q;
   assign bus.pc_sel        = pc_sel_q;
   assign bus.branch_target = target_q;
   assign bus.link_we       = link_we_q;
   assign bus.link_value    = link_q;
   assign bus.rd_we         = rd_we_q;
   assign bus.rd_value      = rd_q;
   assign bus.trap_req      = trap_req_q;
   assign bus.trap_pc       = trap_pc_q;
   assign bus.flush         = flush_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Stage directly downstream of the ALU comparator. It consumes the comparator's 4-bit carry flag and the move result, and resolves each instruction:
- branches: PC redirect, plus link write for branch-and-link
- traps: trap request handshake with the exception controller
- conditional moves (MOVZ/MOVN): register write enable
It also sequences pipeline flush and stall. It sits between the execute stage and the PC/writeback/exception logic.

Parameters:
FLUSH_CYCLES, 1, cycles of flush asserted after a taken branch (range 0..15).
RESET_VECTOR, 32'h0000_0000, value driven on branch_target and trap_pc during and after reset.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous reset, active-low; sampled on rising edge of clk.
valid_in  in  1  instruction presented this cycle.
ready_out  out  1  unit can accept; a transfer occurs when valid_in && ready_out.
op_class  in  3  000 none, 001 branch, 010 branch-and-link, 011 trap, 100 cond-move; 101-111 treated as none.
flag_sel  in  2  condition source: 00 carry_flag[0], 01 carry_flag[2] (signed), 10 carry_flag[3] (unsigned), 11 unconditional true.
carry_flag  in  4  comparator flag vector.
pc_in  in  32  PC of the instruction.
offset_in  in  16  branch offset, in words.
move_value  in  32  comparator regDestination result for cond-move.
trap_ack  in  1  exception controller accepts the trap.
pc_sel  out  1  one-cycle pulse: take branch_target.
branch_target  out  32  resolved target.
link_we  out  1  one-cycle pulse: write link_value to r31.
link_value  out  32  pc_in + 8.
rd_we  out  1  one-cycle pulse: cond-move write.
rd_value  out  32  registered move_value.
trap_req  out  1  level; held until acknowledged.
trap_pc  out  32  PC of the trapping instruction.
flush  out  1  squash younger instructions.

Behaviour:
- Reset (reset==0 at an edge):
  - next state IDLE.
  - All 1-bit outputs 0; ready_out 0 during reset, 1 on the first cycle after reset is released.
  - branch_target and trap_pc = RESET_VECTOR; link_value and rd_value = 0.
  - Reset overrides everything, including mid-FLUSH and mid-TRAP_WAIT; no pending trap or flush survives.
- Condition: cond = the bit chosen by flag_sel; always 1 when flag_sel = 11.
- Arithmetic, all modulo 2^32 (wrap-around, no overflow detection):
  - target = pc_in + 4 + (sign_extend(offset_in) << 2).
  - link = pc_in + 8.
- States and transitions:
  - IDLE: ready_out=1. On accept, registered outputs are updated at the same edge, so results are visible the next cycle (latency 1).
    - branch / branch-and-link, cond=1: pc_sel=1 and branch_target=target for 1 cycle. Branch-and-link also gives link_we=1 and link_value=link for the same cycle. If FLUSH_CYCLES>0, go to FLUSH, otherwise stay IDLE.
    - branch / branch-and-link, cond=0: no pulses. link_we is not asserted for a not-taken branch-and-link. Stay IDLE.
    - trap, cond=1: trap_req=1, trap_pc=pc_in; go to TRAP_WAIT.
    - trap, cond=0: no effect.
    - cond-move, cond=1: rd_we=1, rd_value=move_value for 1 cycle.
    - cond-move, cond=0: no write.
    - none: no effect.
  - FLUSH: flush=1 and ready_out=0 for exactly FLUSH_CYCLES cycles, starting the cycle pc_sel is high; then IDLE. valid_in is ignored.
  - TRAP_WAIT: trap_req=1, ready_out=0.
    - trap_ack is sampled only while trap_req=1; an ack when trap_req=0 is ignored.
    - trap_ack=1 at an edge: trap_req=0 the next cycle, return to IDLE.
    - Ack in the first cycle trap_req is high is legal.
- Pulse outputs (pc_sel, link_we, rd_we) are never high for more than 1 cycle per accepted instruction.
- Back-to-back accepts in IDLE are allowed every cycle when nothing is taken.

Test Plan:
1. Taken branch, FLUSH_CYCLES=1: op=001, flag_sel=00, carry_flag=0001, pc_in=0x00400010, offset=0xFFFC -> next cycle pc_sel=1, branch_target=0x00400004, flush=1, ready_out=0 for 1 cycle, then ready_out=1.
2. Not taken, then back-to-back: op=001, carry_flag=0000 for 3 consecutive accepts -> pc_sel, flush and link_we stay 0; ready_out stays 1.
3. Branch-and-link taken, with wrap: op=010, flag_sel=11, pc_in=0xFFFFFFF0, offset=0x0010 -> branch_target=0x00000034, link_we=1, link_value=0xFFFFFFF8.
4. Trap handshake: op=011, flag_sel=01, carry_flag=0100, pc_in=0x00400020; trap_ack held 0 for 3 cycles, then 1 -> trap_req=1 and trap_pc=0x00400020 for 4 cycles, trap_req=0 the next cycle, ready_out=0 throughout; a stray trap_ack beforehand is ignored.
5. Cond-move: op=100, flag_sel=00, move_value=0xDEADBEEF, carry_flag=0001 -> rd_we=1, rd_value=0xDEADBEEF for 1 cycle. Repeat with carry_flag=0000 -> rd_we stays 0.
6. Reset mid-operation: assert reset=0 during TRAP_WAIT and, separately, mid-FLUSH with FLUSH_CYCLES=4 -> at the next edge trap_req=0, flush=0, branch_target=RESET_VECTOR; ready_out=1 the cycle after reset is released.
